window_line_buffer: RTL and testbench

- Parametrised K x K sliding-window generator for streaming raster pixels. It is the next generation of the fixed 7-tap single-line shift buffer.
- Holds K-1 full lines in circular line memories and a K x K window register array.
- Emits one complete window per accepted pixel once the window lies fully inside the frame.
- Supports a runtime line width (at most IMG_Width), input-valid stalls, frame restart and per-line flags.
- Sits between the pixel source and the convolution / pooling engines.

---
 rtl/window_line_buffer.sv | 191 +++++++++++++++++++
 tb/tb_window_line_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_line_buffer.sv
// window_line_buffer: K x K sliding window over a streamed raster image.
// Optional extra output register stage: define WLB_OUT_REG_EN.
module window_line_buffer #(
   parameter int IMG_Width = 224,
   parameter int Datawidth = 8,
   parameter int K         = 7
) (
   input  logic                       CLK,
   input  logic                       CLR,
   input  logic                       IN_VALID,
   input  logic                       IN_SOF,
   input  logic [Datawidth-1:0]       In,
   input  logic [7:0]                 LINE_W,
   output logic [K*K*Datawidth-1:0]   WIN,
   output logic                       OUT_VALID,
   output logic                       LINE_END,
   output logic                       CFG_ERR
);

   localparam int AW = (IMG_Width > 1) ? $clog2(IMG_Width) : 1;
   localparam int WW = $clog2(IMG_Width + 1);
   localparam int RW = $clog2(K);
   localparam int L  = K - 1;

   localparam logic [WW-1:0] WMAX  = WW'(IMG_Width);
   localparam logic [WW-1:0] WMIN  = WW'(K);
   localparam logic [WW-1:0] CFIRST = WW'(K - 1);
   localparam logic [RW-1:0] RLAST = RW'(K - 1);
   localparam logic [31:0]   KU    = K;
   localparam logic [31:0]   IU    = IMG_Width;

   typedef logic [Datawidth-1:0] pix_t;

   // Counters, latched width and flags
   logic [AW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [WW-1:0] wid_q, wid_d;
   logic          err_q, err_d;
   logic          ov_q, ov_d;
   logic          le_q, le_d;

   // Effective position of the pixel being accepted
   logic [AW-1:0] col_e;
   logic [RW-1:0] row_e;
   logic [WW-1:0] wid_e;
   logic          sof;
   logic          last_col;

   // Width clamp of LINE_W
   logic          lw_lo;
   logic          lw_hi;
   logic [WW-1:0] lw_cl;

   // Line memories and window
   pix_t                        mem [L][IMG_Width];
   pix_t [L-1:0]                rd;
   pix_t [K-1:0]                colv;
   pix_t [K-1:0][K-1:0]         win_q, win_d;

   // Clamp the requested width into K..IMG_Width
   always_comb begin
      lw_lo = ({24'd0, LINE_W} < KU);
      lw_hi = ({24'd0, LINE_W} > IU);
      if (lw_lo) begin
         lw_cl = WMIN;
      end else if (lw_hi) begin
         lw_cl = WMAX;
      end else begin
         lw_cl = WW'(LINE_W);
      end
   end

   // SOF overrides position and width in the accepting cycle
   always_comb begin
      sof      = IN_VALID & IN_SOF;
      col_e    = sof ? '0 : col_q;
      row_e    = sof ? '0 : row_q;
      wid_e    = sof ? lw_cl : wid_q;
      last_col = (WW'(col_e) == (wid_e - WW'(1)));
   end

   // Next-state for counters and output flags
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      wid_d = wid_q;
      err_d = err_q;
      ov_d  = 1'b0;
      le_d  = 1'b0;
      if (IN_VALID) begin
         wid_d = wid_e;
         err_d = err_q | (sof & (lw_lo | lw_hi));
         if (last_col) begin
            col_d = '0;
            row_d = (row_e == RLAST) ? RLAST
                                     : row_e + RW'(1);
         end else begin
            col_d = col_e + AW'(1);
            row_d = row_e;
         end
         ov_d = (row_e == RLAST) &&
                (WW'(col_e) >= CFIRST);
         le_d = last_col;
      end
   end

   // Read all line memories at the current column
   always_comb begin
      for (int j = 0; j < L; j++) begin
         rd[j] = mem[j][col_e];
      end
   end

   // Column vector oldest to newest, then shift window left
   always_comb begin
      for (int r = 0; r < L; r++) begin
         colv[r] = rd[L-1-r];
      end
      colv[K-1] = In;
      win_d = win_q;
      if (IN_VALID) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = colv[r];
         end
      end
   end

   // Line memories cascade: read-before-write per column
   always_ff @(posedge CLK) begin
      if (IN_VALID) begin
         mem[0][col_e] <= In;
         for (int j = 1; j < L; j++) begin
            mem[j][col_e] <= mem[j-1][col_e];
         end
      end
   end

   // Control and window state registers
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         col_q <= '0;
         row_q <= '0;
         wid_q <= WMAX;
         err_q <= 1'b0;
         ov_q  <= 1'b0;
         le_q  <= 1'b0;
         win_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         wid_q <= wid_d;
         err_q <= err_d;
         ov_q  <= ov_d;
         le_q  <= le_d;
         win_q <= win_d;
      end
   end

`ifdef WLB_OUT_REG_EN
   logic [K*K*Datawidth-1:0] win_s_q;
   logic                     ov_s_q;
   logic                     le_s_q;

   // Free-running output stage, one extra cycle of latency
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         win_s_q <= '0;
         ov_s_q  <= 1'b0;
         le_s_q  <= 1'b0;
      end else begin
         win_s_q <= win_q;
         ov_s_q  <= ov_q;
         le_s_q  <= le_q;
      end
   end

   assign WIN       = win_s_q;
   assign OUT_VALID = ov_s_q;
   assign LINE_END  = le_s_q;
`else
   assign WIN       = win_q;
   assign OUT_VALID = ov_q;
   assign LINE_END  = le_q;
`endif

   assign CFG_ERR = err_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: scoreboard bench for window_line_buffer.
// K=3, IMG_Width=8, pixel value = row*16+col.
module tb_window_line_buffer;

   localparam int K  = 3;
   localparam int IW = 8;
   localparam int DW = 8;
`ifdef WLB_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [K*K*DW-1:0] w;
      int                c;
   } exp_t;

   logic              CLK;
   logic              CLR;
   logic              IN_VALID;
   logic              IN_SOF;
   logic [DW-1:0]     In;
   logic [7:0]        LINE_W;
   logic [K*K*DW-1:0] WIN;
   logic              OUT_VALID;
   logic              LINE_END;
   logic              CFG_ERR;

   exp_t exp_q[$];
   int   le_q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;
   int   cur_w = 5;
   bit   mon_en = 1'b1;

   window_line_buffer #(
      .IMG_Width(IW),
      .Datawidth(DW),
      .K(K)
   ) dut (
      .CLK(CLK),
      .CLR(CLR),
      .IN_VALID(IN_VALID),
      .IN_SOF(IN_SOF),
      .In(In),
      .LINE_W(LINE_W),
      .WIN(WIN),
      .OUT_VALID(OUT_VALID),
      .LINE_END(LINE_END),
      .CFG_ERR(CFG_ERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   function automatic logic [K*K*DW-1:0] mkwin(input int y, input int x);
      logic [K*K*DW-1:0] v;
      v = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            v[(r*K+c)*DW +: DW] = 8'((y-K+1+r)*16 + (x-K+1+c));
         end
      end
      return v;
   endfunction

   // Monitor: pop and compare whenever the DUT presents an output
   always @(negedge CLK) begin
      if (mon_en && CLR) begin
         while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            nvec++;
            nerr++;
            $display("FAIL ov_missed: got none want window %0h at cycle %0d",
                     exp_q[0].w, exp_q[0].c);
            exp_q.delete(0);
         end
         while (le_q.size() > 0 && le_q[0] < cyc) begin
            nvec++;
            nerr++;
            $display("FAIL le_missed: got none want pulse at cycle %0d", le_q[0]);
            le_q.delete(0);
         end
         if (OUT_VALID) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL ov_unexpected: got window %0h at cycle %0d want none",
                        WIN, cyc);
            end else begin
               chk("ov_cycle", 128'(cyc), 128'(exp_q[0].c));
               chk("win", 128'(WIN), 128'(exp_q[0].w));
               exp_q.delete(0);
            end
         end
         if (LINE_END) begin
            if (le_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL le_unexpected: got pulse at cycle %0d want none", cyc);
            end else begin
               chk("le_cycle", 128'(cyc), 128'(le_q[0]));
               le_q.delete(0);
            end
         end
      end
   end

   task automatic idle(input int n);
      IN_VALID = 1'b0;
      IN_SOF   = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic px(input int y, input int x,
                     input bit sof, input bit expect_en);
      exp_t e;
      IN_VALID = 1'b1;
      IN_SOF   = sof;
      In       = 8'(y*16 + x);
      if (expect_en) begin
         if (y >= K-1 && x >= K-1) begin
            e.w = mkwin(y, x);
            e.c = cyc + LAT;
            exp_q.push_back(e);
         end
         if (x == cur_w - 1) le_q.push_back(cyc + LAT);
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      IN_SOF   = 1'b0;
   endtask

   task automatic frame(input int w, input int h, input int lw,
                        input bit sof, input bit stall);
      cur_w  = w;
      LINE_W = 8'(lw);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            if (stall) begin
               for (int k = 0; k < 4 && $urandom_range(0, 99) < 30; k++)
                  idle(1);
            end
            px(y, x, sof && y == 0 && x == 0, 1'b1);
         end
      end
   endtask

   task automatic drain(input string nm);
      idle(4);
      chk({nm, "_win_left"}, 128'(exp_q.size()), 128'(0));
      chk({nm, "_le_left"}, 128'(le_q.size()), 128'(0));
   endtask

   initial begin
      CLR      = 1'b0;
      IN_VALID = 1'b0;
      IN_SOF   = 1'b0;
      In       = '0;
      LINE_W   = 8'd5;
      #3;
      chk("rst_win", 128'(WIN), 128'(0));
      chk("rst_ov", 128'(OUT_VALID), 128'(0));
      chk("rst_le", 128'(LINE_END), 128'(0));
      chk("rst_err", 128'(CFG_ERR), 128'(0));
      #9;
      CLR = 1'b1;
      @(posedge CLK);
      #1;

      frame(5, 4, 5, 1'b1, 1'b0);
      drain("ramp");

      frame(5, 4, 5, 1'b1, 1'b1);
      drain("stall");

      cur_w  = 5;
      LINE_W = 8'd5;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 5; x++)
            px(y, x, y == 0 && x == 0, 1'b1);
      for (int x = 0; x < 3; x++) px(2, x, 1'b0, 1'b1);
      frame(5, 4, 5, 1'b1, 1'b0);
      drain("midsof");
      chk("err_before_clamp", 128'(CFG_ERR), 128'(0));

      frame(3, 3, 2, 1'b1, 1'b0);
      drain("clamp");
      chk("err_set", 128'(CFG_ERR), 128'(1));

      frame(5, 4, 5, 1'b1, 1'b0);
      drain("after_clamp");
      chk("err_sticky", 128'(CFG_ERR), 128'(1));

      mon_en = 1'b0;
      cur_w  = 5;
      LINE_W = 8'd5;
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 5; x++)
            px(y, x, y == 0 && x == 0, 1'b0);
      for (int x = 0; x < 4; x++) px(2, x, 1'b0, 1'b0);
      #2;
      chk("pre_rst_ov", 128'(OUT_VALID), 128'(1));
      chk("pre_rst_err", 128'(CFG_ERR), 128'(1));
      CLR = 1'b0;
      #1;
      chk("async_rst_win", 128'(WIN), 128'(0));
      chk("async_rst_ov", 128'(OUT_VALID), 128'(0));
      chk("async_rst_le", 128'(LINE_END), 128'(0));
      chk("async_rst_err", 128'(CFG_ERR), 128'(0));
      #1;
      CLR = 1'b1;
      exp_q.delete();
      le_q.delete();
      @(posedge CLK);
      #1;
      mon_en = 1'b1;

      frame(IW, 3, 5, 1'b0, 1'b0);
      drain("nosof");

      frame(5, 4, 5, 1'b1, 1'b0);
      drain("post_rst");
      chk("err_cleared", 128'(CFG_ERR), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
